uart_tx_scheduler: RTL and testbench

Round-robin scheduler that shares the single UART transmit serializer among NUM_REQ byte producers (CPU path, debug console, DMA, and similar). It accepts one byte at a time over per-requester valid/ready handshakes and presents the byte on tx_data. It pulses tx_start, then tracks the serializer's tx_busy through the whole frame. It enforces a configurable idle gap between frames and flags a serializer that never goes busy.

---
 rtl/uart_tx_scheduler.sv | 129 ++++++++++++
 tb/tb_uart_tx_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter that shares one UART transmit serializer among NUM_REQ byte producers.
// It tracks the serializer's busy handshake, inserts an idle gap between frames and flags a serializer that never goes busy.
module uart_tx_scheduler #(
  parameter  int NUM_REQ      = 4,
  parameter  int GAP_CYCLES   = 1,
  parameter  int BUSY_TIMEOUT = 4,
  localparam int IW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   tx_clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic [IW-1:0]          grant_id,
  output logic                   active,
  output logic                   err_timeout,
  input  logic                   err_clear
);

  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  localparam logic [15:0] TO_LAST  = 16'(BUSY_TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  state_t        state;
  logic [IW-1:0] ptr;
  logic [15:0]   cnt;

  logic [7:0]    bytes [NUM_REQ];
  logic          found_hi, found_lo, any_valid;
  logic [IW-1:0] win_hi, win_lo, win;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      bytes[i] = req_data[8*i +: 8];
    end
  end

  // Rotating priority: first valid above ptr wins, otherwise wrap to the lowest valid at or below ptr.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i]) begin
        if (i > 32'(ptr)) begin
          if (!found_hi) begin
            found_hi = 1'b1;
            win_hi   = IW'(i);
          end
        end else if (!found_lo) begin
          found_lo = 1'b1;
          win_lo   = IW'(i);
        end
      end
    end
    win       = found_hi ? win_hi : win_lo;
    any_valid = found_hi | found_lo;
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && any_valid) req_ready[win] = 1'b1;
  end

  always_ff @(posedge tx_clk) begin
    if (!rst) begin
      state       <= IDLE;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      active      <= 1'b0;
      err_timeout <= 1'b0;
      ptr         <= IW'(NUM_REQ - 1);
      cnt         <= '0;
    end else begin
      tx_start <= 1'b0;
      // A timeout set later in this block overrides a simultaneous clear.
      if (err_clear) err_timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_valid) begin
            tx_data  <= bytes[win];
            grant_id <= win;
            ptr      <= win;
            tx_start <= 1'b1;
            active   <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (cnt == TO_LAST) begin
            err_timeout <= 1'b1;
            cnt         <= '0;
            state       <= GAP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            cnt   <= '0;
            state <= GAP;
          end
        end
        GAP: begin
          if (GAP_CYCLES == 0 || cnt == GAP_LAST) begin
            active <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: table-driven frames, hand-written corner sequences, and randomized traffic checked against a cycle-level model.
// A second instance with GAP_CYCLES=0 sees identical stimulus; its single-cycle GAP state gives it the same timing as the main instance.
module tb_uart_tx_scheduler;

  localparam int T = 4;

  logic        tx_clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic        tx_busy;
  logic        err_clear;

  logic [3:0]  req_ready, r0;
  logic [7:0]  tx_data, td0;
  logic        tx_start, ts0;
  logic [1:0]  grant_id, gid0;
  logic        active, act0;
  logic        err_timeout, err0;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_scheduler #(.NUM_REQ(4), .GAP_CYCLES(1), .BUSY_TIMEOUT(T)) dut (
    .tx_clk(tx_clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .grant_id(grant_id), .active(active), .err_timeout(err_timeout), .err_clear(err_clear)
  );

  uart_tx_scheduler #(.NUM_REQ(4), .GAP_CYCLES(0), .BUSY_TIMEOUT(T)) dut0 (
    .tx_clk(tx_clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(r0), .tx_data(td0), .tx_start(ts0), .tx_busy(tx_busy),
    .grant_id(gid0), .active(act0), .err_timeout(err0), .err_clear(err_clear)
  );

  always #5 tx_clk = ~tx_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(negedge tx_clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  er;
    int          eg;
    logic [7:0]  eb;
    int          len;
  } vec_t;

  vec_t tbl [12];

  // Starts in an idle cycle with req_valid low; ends in the next idle cycle.
  // len=0 means the serializer never goes busy (timeout path).
  task automatic run_frame(input logic [3:0] v, input logic [31:0] d, input logic [3:0] er,
                           input int eg, input logic [7:0] eb, input int len,
                           input bit clr_at_to, input bit exp_err);
    req_valid = v;
    req_data  = d;
    #1;
    chk("ready", req_ready, er);
    chk("ready_g0", r0, er);
    if (er == 4'b0000) begin
      chk("gid_hold", grant_id, eg);
      chk("data_hold", tx_data, eb);
      chk("idle_active", active, 0);
      req_valid = '0;
      return;
    end
    nxt(); #1;
    chk("start", tx_start, 1);
    chk("start_g0", ts0, 1);
    chk("data", tx_data, eb);
    chk("gid", grant_id, eg);
    chk("active", active, 1);
    chk("ready_start", req_ready, 0);
    if (len == 0) begin
      for (int i = 0; i < T; i++) begin
        nxt();
        err_clear = clr_at_to && (i == T - 1);
        #1;
        chk("start_once", tx_start, 0);
        chk("ready_wait", req_ready, 0);
      end
      nxt();
      err_clear = 1'b0;
      #1;
      chk("err_set", err_timeout, 1);
      chk("err_set_g0", err0, 1);
      chk("ready_gap", req_ready, 0);
      chk("active_gap", active, 1);
    end else begin
      nxt();
      tx_busy = 1'b1;
      #1;
      chk("start_once", tx_start, 0);
      for (int i = 1; i < len; i++) begin
        nxt(); #1;
        chk("start_busy", tx_start, 0);
        chk("ready_busy", req_ready, 0);
        chk("ready_busy_g0", r0, 0);
        chk("active_busy", active, 1);
      end
      nxt();
      tx_busy = 1'b0;
      #1;
      chk("ready_fall", req_ready, 0);
      chk("active_fall", active, 1);
      nxt(); #1;
      chk("ready_gap", req_ready, 0);
      chk("ready_gap_g0", r0, 0);
      chk("active_gap", active, 1);
    end
    nxt();
    req_valid = '0;
    #1;
    chk("idle", active, 0);
    chk("idle_g0", act0, 0);
    chk("err", err_timeout, exp_err);
  endtask

  // Randomized traffic against a cycle-indexed model: each acceptance schedules
  // the frame's START cycle, timeout cycle and the first cycle a new grant is allowed.
  task automatic random_phase(input int cycles);
    int free_at = 0, start_at = -100, to_cyc = -100, gap_start = 0;
    int bf = -100, bt = -100;
    int ptr = 3, w;
    bit exp_err = 0, b, acc;
    logic [7:0] exp_data = 8'h00;
    int exp_gid = 0;
    logic [3:0] v, er;
    for (int c = 0; c < cycles; c++) begin
      nxt();
      v = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) v = '0;
      req_valid = v;
      req_data  = $urandom;
      err_clear = ($urandom_range(0, 9) == 0);
      b = (c >= bf) && (c < bt);
      if (c >= gap_start && !b && $urandom_range(0, 7) == 0) b = 1'b1;
      tx_busy = b;
      #1;
      acc = (c >= free_at) && (v != 0);
      w = 0;
      er = '0;
      if (acc) begin
        for (int k = 1; k <= 4; k++) begin
          if (er == 0 && v[(ptr + k) % 4]) begin
            w  = (ptr + k) % 4;
            er = 4'b0001 << w;
          end
        end
      end
      chk("r_ready", req_ready, er);
      chk("r_ready_g0", r0, er);
      chk("r_start", tx_start, c == start_at);
      chk("r_start_g0", ts0, c == start_at);
      chk("r_active", active, (c >= start_at) && (c < free_at));
      chk("r_active_g0", act0, (c >= start_at) && (c < free_at));
      chk("r_data", tx_data, exp_data);
      chk("r_gid", grant_id, exp_gid);
      chk("r_err", err_timeout, exp_err);
      chk("r_err_g0", err0, exp_err);
      if (c == to_cyc) exp_err = 1'b1;
      else if (err_clear) exp_err = 1'b0;
      if (acc) begin
        exp_data = req_data[8*w +: 8];
        exp_gid  = w;
        ptr      = w;
        start_at = c + 1;
        if ($urandom_range(0, 4) == 0) begin
          bf = -100; bt = -100;
          to_cyc    = c + 1 + T;
          gap_start = c + 2 + T;
          free_at   = c + 3 + T;
        end else begin
          bf = c + 1 + int'($urandom_range(1, T));
          bt = bf + int'($urandom_range(1, 6));
          to_cyc    = -100;
          gap_start = bt + 1;
          free_at   = bt + 2;
        end
      end
    end
    req_valid = '0;
    tx_busy   = 1'b0;
    err_clear = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{4'b0001, 32'h000000A5, 4'b0001, 0, 8'hA5, 11};
    tbl[1]  = '{4'b1111, 32'h13121110, 4'b0010, 1, 8'h11, 2};
    tbl[2]  = '{4'b1111, 32'h13121110, 4'b0100, 2, 8'h12, 3};
    tbl[3]  = '{4'b1111, 32'h13121110, 4'b1000, 3, 8'h13, 1};
    tbl[4]  = '{4'b1111, 32'h13121110, 4'b0001, 0, 8'h10, 2};
    tbl[5]  = '{4'b1000, 32'h13121110, 4'b1000, 3, 8'h13, 2};
    tbl[6]  = '{4'b1001, 32'h13121110, 4'b0001, 0, 8'h10, 2};
    tbl[7]  = '{4'b1001, 32'h13121110, 4'b1000, 3, 8'h13, 2};
    tbl[8]  = '{4'b0110, 32'hDEADBEEF, 4'b0010, 1, 8'hBE, 2};
    tbl[9]  = '{4'b0110, 32'hDEADBEEF, 4'b0100, 2, 8'hAD, 1};
    tbl[10] = '{4'b0000, 32'h13121110, 4'b0000, 2, 8'hAD, 0};
    tbl[11] = '{4'b0101, 32'h13121110, 4'b0001, 0, 8'h10, 2};

    rst = 1'b0; req_valid = '0; req_data = '0; tx_busy = 1'b0; err_clear = 1'b0;
    nxt(); nxt(); nxt();
    chk("rst_start", tx_start, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_active", active, 0);
    chk("rst_err", err_timeout, 0);
    rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_frame(tbl[i].v, tbl[i].d, tbl[i].er, tbl[i].eg, tbl[i].eb, tbl[i].len, 1'b0, 1'b0);
    end

    // Timeout, sticky flag, clear, then set-wins-over-clear.
    run_frame(4'b0001, 32'h13121110, 4'b0001, 0, 8'h10, 0, 1'b0, 1'b1);
    nxt();
    err_clear = 1'b1;
    #1;
    chk("err_sticky", err_timeout, 1);
    nxt();
    err_clear = 1'b0;
    #1;
    chk("err_cleared", err_timeout, 0);
    run_frame(4'b0010, 32'h13121110, 4'b0010, 1, 8'h11, 0, 1'b1, 1'b1);
    run_frame(4'b0001, 32'h13121110, 4'b0001, 0, 8'h10, 3, 1'b0, 1'b1);
    nxt();
    err_clear = 1'b1;
    nxt();
    err_clear = 1'b0;
    #1;
    chk("err_cleared2", err_timeout, 0);

    // Reset while the serializer is mid-frame.
    req_valid = 4'b0100;
    req_data  = 32'h33221100;
    #1;
    chk("pre_rst_ready", req_ready, 4'b0100);
    nxt();
    req_valid = '0;
    #1;
    chk("pre_rst_start", tx_start, 1);
    nxt();
    tx_busy = 1'b1;
    nxt(); #1;
    chk("pre_rst_active", active, 1);
    rst = 1'b0;
    nxt(); #1;
    chk("mid_rst_start", tx_start, 0);
    chk("mid_rst_data", tx_data, 0);
    chk("mid_rst_gid", grant_id, 0);
    chk("mid_rst_active", active, 0);
    chk("mid_rst_err", err_timeout, 0);
    chk("mid_rst_ready", req_ready, 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nxt(); #1;
      chk("post_rst_start", tx_start, 0);
      chk("post_rst_active", active, 0);
    end
    tx_busy   = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("post_rst_ready", req_ready, 4'b0001);
    nxt();
    req_valid = '0;
    #1;
    chk("post_rst_start1", tx_start, 1);
    chk("post_rst_data", tx_data, 8'h00);
    nxt();
    tx_busy = 1'b1;
    nxt();
    tx_busy = 1'b0;
    nxt(); nxt(); #1;
    chk("post_rst_idle", active, 0);

    rst = 1'b0;
    nxt(); nxt();
    rst = 1'b1;
    random_phase(1500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
